// File: rtl/qam_symbol_mapper.sv
// Serial-to-QAM symbol mapper: collects Gray-coded bits per strobe, maps each axis to a signed
// amplitude and queues symbols in a 2-entry valid/ready FIFO.
module qam_symbol_mapper #(
    parameter int BITS_PER_AXIS = 2,
    parameter int AMP_W         = 8,
    parameter int SCALE         = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    bit_in,
    input  logic                    bit_strobe,
    input  logic                    sym_ready,
    output logic                    sym_valid,
    output logic signed [AMP_W-1:0] i_out,
    output logic signed [AMP_W-1:0] q_out,
    output logic                    overflow,
    output logic [15:0]             sym_count
);

    localparam int SYM_BITS = 2 * BITS_PER_AXIS;
    localparam int CNT_W    = (SYM_BITS > 2) ? $clog2(SYM_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYM_BITS - 1);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic signed [AMP_W-1:0] map_axis(input logic [BITS_PER_AXIS-1:0] g);
        logic [BITS_PER_AXIS-1:0] b;
        int                       lvl;
        b = g;
        for (int s = 1; s < BITS_PER_AXIS; s++) begin
            b = b ^ (g >> s);
        end
        lvl = 2 * int'(b) - ((1 << BITS_PER_AXIS) - 1);
        return AMP_W'(lvl * SCALE);
    endfunction

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SYM_BITS-1:0]     shreg_q, shreg_d;
    logic [SYM_BITS-1:0]     sym_bits;
    logic                    sym_done;

    logic [1:0]              count_q, count_d;
    logic signed [AMP_W-1:0] ent_i_q [2];
    logic signed [AMP_W-1:0] ent_i_d [2];
    logic signed [AMP_W-1:0] ent_q_q [2];
    logic signed [AMP_W-1:0] ent_q_d [2];
    logic                    overflow_q, overflow_d;
    logic [15:0]             sym_count_q, sym_count_d;

    logic                    pop;
    logic                    push_ok;
    logic signed [AMP_W-1:0] new_i;
    logic signed [AMP_W-1:0] new_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        sym_done = 1'b0;
        sym_bits = {shreg_q[SYM_BITS-2:0], bit_in};
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StCollect;
            end
            StCollect: begin
                if (!enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else if (bit_strobe) begin
                    shreg_d = sym_bits;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d    = '0;
                        sym_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign new_i = map_axis(sym_bits[SYM_BITS-1 -: BITS_PER_AXIS]);
    assign new_q = map_axis(sym_bits[BITS_PER_AXIS-1:0]);

    // Entry 0 is always the head; it is left untouched when the FIFO drains so the
    // outputs hold the last symbol shown.
    always_comb begin
        count_d     = count_q;
        ent_i_d     = ent_i_q;
        ent_q_d     = ent_q_q;
        overflow_d  = overflow_q;
        sym_count_d = sym_count_q;
        pop         = (count_q != 2'd0) && sym_ready;
        push_ok     = sym_done && ((count_q != 2'd2) || pop);
        case ({push_ok, pop})
            2'b01: begin
                if (count_q == 2'd2) begin
                    ent_i_d[0] = ent_i_q[1];
                    ent_q_d[0] = ent_q_q[1];
                end
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent_i_d[0] = new_i;
                    ent_q_d[0] = new_q;
                end else begin
                    ent_i_d[1] = new_i;
                    ent_q_d[1] = new_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent_i_d[0] = new_i;
                    ent_q_d[0] = new_q;
                end else begin
                    ent_i_d[0] = ent_i_q[1];
                    ent_q_d[0] = ent_q_q[1];
                    ent_i_d[1] = new_i;
                    ent_q_d[1] = new_q;
                end
            end
            default: ;
        endcase
        if (sym_done && !push_ok) overflow_d = 1'b1;
        if (push_ok) sym_count_d = sym_count_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            count_q     <= 2'd0;
            ent_i_q     <= '{default: '0};
            ent_q_q     <= '{default: '0};
            overflow_q  <= 1'b0;
            sym_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            count_q     <= count_d;
            ent_i_q     <= ent_i_d;
            ent_q_q     <= ent_q_d;
            overflow_q  <= overflow_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign sym_valid = (count_q != 2'd0);
    assign i_out     = ent_i_q[0];
    assign q_out     = ent_q_q[0];
    assign overflow  = overflow_q;
    assign sym_count = sym_count_q;

endmodule

// File: doc/qam_symbol_mapper.md
Name: qam_symbol_mapper

Overview:
- Downstream consumer of the serial data generator.
- Samples one bit per generator strobe and groups 2*BITS_PER_AXIS bits into a QAM symbol.
- Maps each axis Gray-coded to a signed I/Q amplitude and buffers symbols in a 2-entry FIFO with valid/ready towards the modulator.
- Default: 16-QAM, levels ±32/±96.

Parameters:
- BITS_PER_AXIS, 2: bits per I and per Q axis; symbol = 2*BITS_PER_AXIS bits.
- AMP_W, 8: signed output amplitude width; (2^BITS_PER_AXIS-1)*SCALE must fit signed AMP_W.
- SCALE, 32: amplitude of one level step (odd-integer multiplier).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  collection enable; low = idle, partial symbol discarded.
- bit_in  in  1  serial data bit from generator.
- bit_strobe  in  1  one-cycle pulse; bit_in is valid and sampled on this cycle.
- sym_ready  in  1  downstream accepts head symbol when high with sym_valid.
- sym_valid  out  1  FIFO head valid.
- i_out  out  AMP_W  signed I amplitude of head symbol.
- q_out  out  AMP_W  signed Q amplitude of head symbol.
- overflow  out  1  sticky: a completed symbol was dropped.
- sym_count  out  16  number of symbols accepted into FIFO, wraps at 65535->0.

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, bit counter=0, shift reg=0, FIFO empty, sym_valid=0, i_out=0, q_out=0, overflow=0, sym_count=0.
- FSM IDLE: ignore strobes. Enter COLLECT on the cycle after enable is sampled high.
- FSM COLLECT: return to IDLE when enable is sampled low; bit counter and shift reg clear; FIFO contents and flags retained.
- Collection: in COLLECT with bit_strobe=1, shift bit_in into the LSB of the 2*BITS_PER_AXIS shift reg and increment the counter.
- The first received bit is the I MSB. The first BITS_PER_AXIS bits form I; the next BITS_PER_AXIS bits form Q, MSB first.
- Symbol completion: a strobe with counter = 2*BITS_PER_AXIS-1 completes the symbol and resets the counter to 0 in the same cycle.
- Mapping per axis:
  - Convert Gray to binary: b[msb]=g[msb], b[k]=b[k+1]^g[k].
  - level = 2*b - (2^BITS_PER_AXIS - 1).
  - amplitude = level*SCALE, sign-extended to AMP_W.
  - Default table: 00->-96, 01->-32, 11->+32, 10->+96.
- Latency: the completed symbol is written to the FIFO at the clock edge ending the strobe cycle. If the FIFO was empty, sym_valid=1 and i_out/q_out are valid on the next cycle (1-cycle latency).
- FIFO: 2 entries; i_out/q_out always show the head entry.
  - Pop when sym_valid & sym_ready.
  - Push is accepted if count<2, or if count==2 and a pop occurs in the same cycle.
  - Otherwise the symbol is dropped, overflow is set (sticky until reset), and sym_count is not incremented.
  - Simultaneous push and pop at count 1 leaves count 1 with the new symbol at the head.
  - When empty: sym_valid=0 and i_out/q_out hold their last values.
- sym_count increments by 1 per accepted push.
- bit_strobe in IDLE or on the same cycle enable is sampled low: ignored.
- Strobe every cycle must be supported; no minimum strobe spacing.
- Reset mid-symbol: partial bits lost, FIFO flushed.

Test Plan:
- Reset, enable=1, feed bits 0,1,1,0 with strobes spaced 512 cycles, sym_ready=1 -> one symbol with I=-32, Q=+96, sym_valid high for exactly 1 cycle, sym_count=1.
- Feed the 28-bit generator pattern 0110_1100_1100_0001_0101_0101_0101 MSB first -> symbols (I,Q): (-32,+96), (+32,-96), (+32,-96), (-96,-32), (-32,-32), (-32,-32), (-32,-32).
- sym_ready=0, feed 3 symbols back to back with a strobe every cycle -> first two held (sym_valid=1, head unchanged), third dropped, overflow=1, sym_count=2. Then raise sym_ready -> two pops in order, then sym_valid=0.
- FIFO full with sym_ready=1 on the same cycle the third symbol completes -> no drop, overflow stays 0, sym_count=3.
- Deassert enable after 3 bits of a symbol, re-enable, feed 1,0,1,0 -> output I=+96, Q=+96 (earlier partial bits discarded).
- Assert reset with 1 symbol in the FIFO and 2 partial bits -> next cycle sym_valid=0, i_out=q_out=0, overflow=0, sym_count=0.
